// File: rtl/processor_pkg.sv
// processor_pkg: definitions shared by the execute-stage condition logic.
//   cond_e_t        : the ARM 4-bit condition field encodings (EQ..AL, NV)
//   N_BIT..V_BIT    : bit positions of the flags inside an NZCV vector
//   FLAGW_NZ/CV     : decode flag-write mask bits (upper half / lower half)
package processor_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e_t;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  localparam logic [1:0] FLAGW_NZ = 2'b10;
  localparam logic [1:0] FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_exmem_stage_if.sv
// cond_exmem_stage_if: bundle between the execute stage and the EX/MEM stage.
//   stall_i/flush_i            : pipeline hazard controls
//   *_e                        : E-stage instruction, controls, data, ALU flags
//   cond_ex_e/branch_taken_e   : combinational condition results
//   flags_q                    : architectural NZCV register
//   *_m                        : registered M-stage controls and data
// master drives the E side, slave (the stage) drives the results.
interface cond_exmem_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
);
  logic             stall_i;
  logic             flush_i;
  logic             valid_e;
  logic [3:0]       cond_e;
  logic [1:0]       flag_w_e;
  logic             reg_w_e;
  logic             mem_w_e;
  logic             pcs_e;
  logic             mem_to_reg_e;
  logic [RA_W-1:0]  wa3_e;
  logic [WIDTH-1:0] alu_result_e;
  logic [WIDTH-1:0] write_data_e;
  logic [3:0]       alu_flags_e;
  logic             cond_ex_e;
  logic             branch_taken_e;
  logic [3:0]       flags_q;
  logic             valid_m;
  logic             reg_w_m;
  logic             mem_w_m;
  logic             pcs_m;
  logic             mem_to_reg_m;
  logic [RA_W-1:0]  wa3_m;
  logic [WIDTH-1:0] alu_result_m;
  logic [WIDTH-1:0] write_data_m;

  modport master (
    output stall_i, flush_i, valid_e, cond_e, flag_w_e, reg_w_e, mem_w_e,
           pcs_e, mem_to_reg_e, wa3_e, alu_result_e, write_data_e, alu_flags_e,
    input  cond_ex_e, branch_taken_e, flags_q, valid_m, reg_w_m, mem_w_m,
           pcs_m, mem_to_reg_m, wa3_m, alu_result_m, write_data_m
  );

  modport slave (
    input  stall_i, flush_i, valid_e, cond_e, flag_w_e, reg_w_e, mem_w_e,
           pcs_e, mem_to_reg_e, wa3_e, alu_result_e, write_data_e, alu_flags_e,
    output cond_ex_e, branch_taken_e, flags_q, valid_m, reg_w_m, mem_w_m,
           pcs_m, mem_to_reg_m, wa3_m, alu_result_m, write_data_m
  );
endinterface

// File: rtl/cond_exmem_stage_cond_check.sv
// cond_check: purely combinational ARM condition evaluator.
//   cond    : 4-bit condition field
//   flags   : NZCV vector to test against
//   cond_ex : 1 when the condition holds (NV never holds)
module cond_check
  import processor_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[N_BIT];
  assign z_s = flags[Z_BIT];
  assign c_s = flags[C_BIT];
  assign v_s = flags[V_BIT];

  // Condition-field decode; NV and any unlisted code fall to "not executed".
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z_s;
      COND_NE: cond_ex = ~z_s;
      COND_CS: cond_ex = c_s;
      COND_CC: cond_ex = ~c_s;
      COND_MI: cond_ex = n_s;
      COND_PL: cond_ex = ~n_s;
      COND_VS: cond_ex = v_s;
      COND_VC: cond_ex = ~v_s;
      COND_HI: cond_ex = c_s & ~z_s;
      COND_LS: cond_ex = ~c_s | z_s;
      COND_GE: cond_ex = (n_s == v_s);
      COND_LT: cond_ex = (n_s != v_s);
      COND_GT: cond_ex = ~z_s & (n_s == v_s);
      COND_LE: cond_ex = z_s | (n_s != v_s);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_exmem_stage.sv
// cond_exmem_stage: execute-stage condition unit and EX/MEM pipeline register.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : cond_exmem_stage_if slave port (E inputs, hazards, results)
// Holds NZCV, evaluates the E-stage condition against the pre-update flags,
// updates flags under the write mask and registers qualified controls/data.
module cond_exmem_stage
  import processor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cond_exmem_stage_if.slave   bus
);
  logic             cond_ex_s;
  logic             q_s;
  logic [3:0]       flags_r;
  logic             valid_r, reg_w_r, mem_w_r, pcs_r, mem_to_reg_r;
  logic [RA_W-1:0]  wa3_r;
  logic [WIDTH-1:0] alu_result_r, write_data_r;

  cond_check u_cond_check (
    .cond    (bus.cond_e),
    .flags   (flags_r),
    .cond_ex (cond_ex_s)
  );

  // Instruction qualifier: real, condition passed, not squashed.
  always_comb begin
    q_s = bus.valid_e & cond_ex_s & ~bus.flush_i;
  end

  // NZCV register: each half loads independently under its mask bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (!bus.stall_i && q_s) begin
      if ((bus.flag_w_e & FLAGW_NZ) != 2'b00) begin
        flags_r[N_BIT:Z_BIT] <= bus.alu_flags_e[N_BIT:Z_BIT];
      end
      if ((bus.flag_w_e & FLAGW_CV) != 2'b00) begin
        flags_r[C_BIT:V_BIT] <= bus.alu_flags_e[C_BIT:V_BIT];
      end
    end
  end

  // EX/MEM register: stall holds everything, flush inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r      <= 1'b0;
      reg_w_r      <= 1'b0;
      mem_w_r      <= 1'b0;
      pcs_r        <= 1'b0;
      mem_to_reg_r <= 1'b0;
      wa3_r        <= {RA_W{1'b0}};
      alu_result_r <= {WIDTH{1'b0}};
      write_data_r <= {WIDTH{1'b0}};
    end else if (!bus.stall_i) begin
      if (bus.flush_i) begin
        valid_r      <= 1'b0;
        reg_w_r      <= 1'b0;
        mem_w_r      <= 1'b0;
        pcs_r        <= 1'b0;
        mem_to_reg_r <= 1'b0;
      end else begin
        valid_r      <= bus.valid_e;
        reg_w_r      <= q_s & bus.reg_w_e;
        mem_w_r      <= q_s & bus.mem_w_e;
        pcs_r        <= q_s & bus.pcs_e;
        // Loads follow validity only; a failed load still has reg_w_m low.
        mem_to_reg_r <= bus.valid_e & bus.mem_to_reg_e;
      end
      wa3_r        <= bus.wa3_e;
      alu_result_r <= bus.alu_result_e;
      write_data_r <= bus.write_data_e;
    end
  end

  assign bus.cond_ex_e      = cond_ex_s;
  assign bus.branch_taken_e = bus.valid_e & bus.pcs_e & cond_ex_s;
  assign bus.flags_q        = flags_r;
  assign bus.valid_m        = valid_r;
  assign bus.reg_w_m        = reg_w_r;
  assign bus.mem_w_m        = mem_w_r;
  assign bus.pcs_m          = pcs_r;
  assign bus.mem_to_reg_m   = mem_to_reg_r;
  assign bus.wa3_m          = wa3_r;
  assign bus.alu_result_m   = alu_result_r;
  assign bus.write_data_m   = write_data_r;
endmodule

// File: doc/cond_exmem_stage.md
Name: cond_exmem_stage

Overview:
- Sits directly downstream of the ALU in the execute stage of the pipelined processor.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit ARM condition field against it.
- Updates the flags from the ALU's ALUFlags output under a per-field write mask.
- Registers the condition-qualified control and data into the EX/MEM pipeline register (1-cycle latency, stall/flush aware).

Parameters:
- WIDTH, 32, datapath width of ALU result and store data
- RA_W, 4, register-file address width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall_i  input  1  hold M register and flags this cycle
- flush_i  input  1  squash the E-stage instruction (bubble into M)
- valid_e  input  1  E-stage holds a real instruction
- cond_e  input  4  ARM condition field
- flag_w_e  input  2  [1]=write N,Z; [0]=write C,V
- reg_w_e, mem_w_e, pcs_e, mem_to_reg_e  input  1 each  raw decode controls
- wa3_e  input  RA_W  destination register
- alu_result_e  input  WIDTH  ALU Result
- write_data_e  input  WIDTH  store data
- alu_flags_e  input  4  ALU ALUFlags {N,Z,C,V}
- cond_ex_e  output  1  condition passed (combinational)
- branch_taken_e  output  1  valid_e & pcs_e & cond_ex_e (combinational)
- flags_q  output  4  current NZCV register
- valid_m, reg_w_m, mem_w_m, pcs_m, mem_to_reg_m  output  1 each  registered M-stage controls
- wa3_m  output  RA_W  registered destination
- alu_result_m, write_data_m  output  WIDTH  registered data

Behaviour:
- Reset (async on rst_n low, released synchronously by clk):
  - flags_q=4'b0000.
  - All M outputs 0.
- Condition evaluation uses flags_q (the value before this cycle's update):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111: always 0 (never executes).
- Qualifier: q = valid_e & cond_ex_e & ~flush_i.
- Flag update on clk edge when ~stall_i & q:
  - flag_w_e[1] loads flags_q[3:2] from alu_flags_e[3:2].
  - flag_w_e[0] loads flags_q[1:0] from alu_flags_e[1:0].
  - Unselected halves hold.
- M register priority: stall_i > flush_i > normal.
  - stall_i=1: all M outputs and flags hold, including when flush_i=1 in the same cycle.
  - flush_i=1, stall_i=0: valid_m and all write-enables/pcs_m/mem_to_reg_m go to 0; wa3_m and data registers load their inputs (don't-care).
  - Normal:
    - valid_m=valid_e.
    - reg_w_m=q&reg_w_e; mem_w_m=q&mem_w_e; pcs_m=q&pcs_e; mem_to_reg_m=valid_e&mem_to_reg_e.
    - wa3_m, alu_result_m, write_data_m load their E inputs.
- Failed condition: the instruction still advances (valid_m=1) but carries no side effects: no reg/mem write, no PC write, no flag write.
- Back-to-back flag setting and use works without forwarding: the flag-setting instruction writes at its E edge, before the next instruction is evaluated.
- Latency: E inputs appear on M outputs one cycle later. cond_ex_e and branch_taken_e have zero latency.
- valid_e=0 forces cond_ex_e-qualified outputs low; cond_ex_e itself still reflects cond_e.

Decomposition:
- Shared package (processor_pkg):
  - cond_e enum (EQ..AL, NV).
  - NZCV bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - FLAGW_NZ / FLAGW_CV mask constants.
- One natural combinational sub-module, cond_check: inputs cond, flags; output cond_ex. It is instantiated once and reusable by decode for static prediction.
- Flag register and EX/MEM register stay in the parent.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with valid_e=1, reg_w_e=1 -> immediately flags_q=0000, valid_m=0, reg_w_m=0, alu_result_m=0.
- CMP then BEQ:
  - Cycle 1: valid_e=1, cond_e=1110, flag_w_e=11, alu_flags_e=0110 -> flags_q=0110 next cycle.
  - Cycle 2: cond_e=0000, pcs_e=1 -> branch_taken_e=1, pcs_m=1 after the edge.
- Masked flag write: flags_q=1001, flag_w_e=10, alu_flags_e=0110, cond AL -> flags_q=0101.
- Failed condition: flags_q=0000, cond_e=0000 (EQ), reg_w_e=1, flag_w_e=11, alu_flags_e=1111 -> valid_m=1, reg_w_m=0, flags_q stays 0000.
- Stall/flush:
  - stall_i=1 with alu_result_e=0xDEADBEEF -> M outputs and flags unchanged.
  - stall_i=1 & flush_i=1 -> still unchanged.
  - flush_i=1 alone -> valid_m=0, reg_w_m=0, mem_w_m=0, flags unchanged.
- Signed conditions and NV: flags_q=1001 (N=V=1):
  - GE -> cond_ex_e=1.
  - LT -> 0.
  - GT -> 1.
  - cond_e=1111 -> 0.
